// File: rtl/shot_seq_pkg.sv
//------------------------------------------------------------------------------
// Module : shot_seq_pkg
// Brief  : Shared state encoding, trigger code and result record for the shot sequencer.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package shot_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_SETTLE = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_REPORT = 3'd4
   } state_e;

   localparam logic [1:0] TRIG_SHOT = 2'b11;

   typedef struct packed {
      logic hit;
      logic valid;
   } result_t;

endpackage

`default_nettype wire

// File: rtl/shot_sequencer_if.sv
//------------------------------------------------------------------------------
// Module : shot_sequencer_if
// Brief  : Trigger, display and game-logic signals of the shot sequencer.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface shot_sequencer_if #(
   parameter int AMMO_MAX = 3
) ();
   localparam int AW = $clog2(AMMO_MAX + 1);

   logic [1:0]    shot_state;
   logic          round_start;
   logic          flash_ack;
   logic          light_sense;
   logic          flash_req;
   logic          result_valid;
   logic          result_hit;
   logic [AW-1:0] ammo;
   logic          busy;
   logic          dry_fire;

   modport master (
      output shot_state, round_start, flash_ack, light_sense,
      input  flash_req, result_valid, result_hit, ammo, busy, dry_fire
   );

   modport slave (
      input  shot_state, round_start, flash_ack, light_sense,
      output flash_req, result_valid, result_hit, ammo, busy, dry_fire
   );
endinterface

`default_nettype wire

// File: rtl/shot_timer.sv
//------------------------------------------------------------------------------
// Module : shot_timer
// Brief  : Loadable down-counter with zero flag, shared by settle and sample phases.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module shot_timer #(
   parameter int WIDTH = 4
) (
   input  wire logic             clk,
   input  wire logic             reset_n,
   input  wire logic             load_i,
   input  wire logic [WIDTH-1:0] load_val_i,
   input  wire logic             en_i,
   output logic                  zero_o
);
   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (en_i && (count_q != '0)) begin
         count_q <= count_q - WIDTH'(1);
      end
   end

   assign zero_o = (count_q == '0);
endmodule

`default_nettype wire

// File: rtl/shot_sequencer.sv
//------------------------------------------------------------------------------
// Module : shot_sequencer
// Brief  : Light-gun shot sequencing: ammo, flash request, settle, sample, report.
//          Optional one-deep shot buffer enabled by defining SHOT_BUFFER_EN.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module shot_sequencer
   import shot_seq_pkg::*;
#(
   parameter int AMMO_MAX      = 3,
   parameter int SETTLE_CYCLES = 16,
   parameter int SAMPLE_CYCLES = 8
) (
   input  wire logic       clk,
   input  wire logic       reset_n,
   shot_sequencer_if.slave bus
);
   localparam int AW    = $clog2(AMMO_MAX + 1);
   localparam int T_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
   localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
   localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] SAMPLE_LOAD = TW'(SAMPLE_CYCLES - 1);

   state_e        state_q, state_d;
   logic [AW-1:0] ammo_q, ammo_d;
   logic          pending_q, pending_d;
   logic          acc_q, acc_d;
   logic          dry_q, dry_d;
   result_t       result_q, result_d;

   logic          tmr_load, tmr_en, tmr_zero;
   logic [TW-1:0] tmr_val;

   logic          shot_live, have_ammo, accept_idle, buffer_shot, acc_final;

   // round_start in the same cycle as a shot swallows the shot entirely
   assign shot_live   = (bus.shot_state == TRIG_SHOT) && !bus.round_start;
   assign have_ammo   = (ammo_q != '0);
   assign accept_idle = shot_live && have_ammo && (state_q == ST_IDLE);
   assign acc_final   = acc_q | bus.light_sense;

`ifdef SHOT_BUFFER_EN
   assign buffer_shot = shot_live && have_ammo && (state_q != ST_IDLE) && !pending_q;
`else
   assign buffer_shot = 1'b0;
`endif

   shot_timer #(.WIDTH(TW)) u_timer (
      .clk       (clk),
      .reset_n   (reset_n),
      .load_i    (tmr_load),
      .load_val_i(tmr_val),
      .en_i      (tmr_en),
      .zero_o    (tmr_zero)
   );

   always_comb begin
      state_d      = state_q;
      ammo_d       = ammo_q;
      pending_d    = pending_q;
      acc_d        = acc_q;
      dry_d        = shot_live && !have_ammo;
      result_d     = '{hit: result_q.hit, valid: 1'b0};
      tmr_load     = 1'b0;
      tmr_val      = SAMPLE_LOAD;
      tmr_en       = 1'b0;

      if (bus.round_start) begin
         ammo_d = AW'(AMMO_MAX);
      end else if (accept_idle || buffer_shot) begin
         ammo_d = ammo_q - AW'(1);
      end
      if (buffer_shot) begin
         pending_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept_idle) state_d = ST_REQ;
         end
         ST_REQ: begin
            if (bus.flash_ack) begin
               state_d  = ST_SETTLE;
               tmr_load = 1'b1;
               tmr_val  = SETTLE_LOAD;
            end
         end
         ST_SETTLE: begin
            if (tmr_zero) begin
               state_d  = ST_SAMPLE;
               tmr_load = 1'b1;
               tmr_val  = SAMPLE_LOAD;
               acc_d    = 1'b0;
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_SAMPLE: begin
            acc_d = acc_final;
            if (tmr_zero) begin
               state_d  = ST_REPORT;
               result_d = '{hit: acc_final, valid: 1'b1};
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_REPORT: begin
            // a shot buffered during this very cycle is chained immediately
            state_d   = (pending_q || buffer_shot) ? ST_REQ : ST_IDLE;
            pending_d = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         ammo_q    <= AW'(AMMO_MAX);
         pending_q <= 1'b0;
         acc_q     <= 1'b0;
         dry_q     <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         ammo_q    <= ammo_d;
         pending_q <= pending_d;
         acc_q     <= acc_d;
         dry_q     <= dry_d;
         result_q  <= result_d;
      end
   end

   assign bus.flash_req    = (state_q == ST_REQ);
   assign bus.result_valid = result_q.valid;
   assign bus.result_hit   = result_q.hit;
   assign bus.ammo         = ammo_q;
   assign bus.busy         = (state_q != ST_IDLE);
   assign bus.dry_fire     = dry_q;
endmodule

`default_nettype wire

// File: tb/tb_shot_sequencer.sv
//------------------------------------------------------------------------------
// Module : tb_shot_sequencer
// Brief  : Self-checking bench for shot_sequencer against a timing/ammo model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_shot_sequencer;
   localparam int AMMO_MAX = 3;
   localparam int SETTLE   = 16;
   localparam int SAMPLE   = 8;
   localparam int LAT      = SETTLE + SAMPLE + 1;
   localparam int WIN_LO   = SETTLE + 1;
   localparam int WIN_HI   = SETTLE + SAMPLE;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   compared = 0;
   int   mismatched = 0;
   int   exp_ammo = AMMO_MAX;

   shot_sequencer_if #(.AMMO_MAX(AMMO_MAX)) bus ();

   shot_sequencer #(
      .AMMO_MAX     (AMMO_MAX),
      .SETTLE_CYCLES(SETTLE),
      .SAMPLE_CYCLES(SAMPLE)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Offset 0 is the flash_ack cycle; the sensor counts in the cycles after settling.
   function automatic logic window_hit(input logic [31:0] pat);
      logic r = 1'b0;
      for (int l = WIN_LO; l <= WIN_HI; l++) r |= pat[l];
      return r;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic fire;
      bus.shot_state = 2'b11;
      tick;
      bus.shot_state = 2'($urandom_range(0, 2));
   endtask

   task automatic pulse_round_start;
      bus.round_start = 1'b1;
      tick;
      bus.round_start = 1'b0;
      exp_ammo = AMMO_MAX;
   endtask

   task automatic do_sequence(input int ack_delay, input logic [31:0] pat, input int shot_lat,
                              input int rs_lat, output int lat, output logic hit);
      lat = -1;
      hit = 1'b0;
      repeat (ack_delay) tick;
      bus.flash_ack   = 1'b1;
      bus.light_sense = pat[0];
      for (int l = 1; l <= 60; l++) begin
         tick;
         bus.flash_ack   = 1'b0;
         bus.shot_state  = 2'b00;
         bus.round_start = 1'b0;
         if (bus.result_valid === 1'b1) begin
            lat = l;
            hit = bus.result_hit;
            break;
         end
         bus.light_sense = (l < 32) ? pat[l] : 1'b0;
         if (l == shot_lat) bus.shot_state = 2'b11;
         if (l == rs_lat) bus.round_start = 1'b1;
      end
      bus.light_sense = 1'b0;
   endtask

   task automatic test_reset;
      compared++;
      if ({bus.flash_req, bus.result_valid, bus.result_hit, bus.busy, bus.dry_fire} !== 5'b0) begin
         mismatched++;
         $display("FAIL reset_outputs: got %b required 00000",
                  {bus.flash_req, bus.result_valid, bus.result_hit, bus.busy, bus.dry_fire});
      end
      compared++;
      if (bus.ammo !== 2'(AMMO_MAX)) begin
         mismatched++;
         $display("FAIL reset_ammo: got %0d required %0d", bus.ammo, AMMO_MAX);
      end
   endtask

   task automatic test_full_round;
      int lat;
      logic hit;
      for (int i = 0; i < 3; i++) begin
         fire;
         exp_ammo--;
         compared++;
         if (bus.flash_req !== 1'b1 || bus.ammo !== 2'(exp_ammo)) begin
            mismatched++;
            $display("FAIL round_accept%0d: got req=%b ammo=%0d required req=1 ammo=%0d",
                     i, bus.flash_req, bus.ammo, exp_ammo);
         end
         do_sequence(2, 32'hFFFF_FFFF, -1, -1, lat, hit);
         compared++;
         if (lat != LAT || hit !== 1'b1) begin
            mismatched++;
            $display("FAIL round_result%0d: got lat=%0d hit=%b required lat=%0d hit=1", i, lat, hit, LAT);
         end
         tick;
         compared++;
         if (bus.result_valid !== 1'b0 || bus.result_hit !== 1'b1 || bus.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL round_hold%0d: got valid=%b hit=%b busy=%b required 0 1 0",
                     i, bus.result_valid, bus.result_hit, bus.busy);
         end
      end
   endtask

   task automatic test_dry_fire;
      fire;
      compared++;
      if (bus.dry_fire !== 1'b1 || bus.busy !== 1'b0 || bus.flash_req !== 1'b0 || bus.ammo !== 2'd0) begin
         mismatched++;
         $display("FAIL dry_fire: got dry=%b busy=%b req=%b ammo=%0d required 1 0 0 0",
                  bus.dry_fire, bus.busy, bus.flash_req, bus.ammo);
      end
      tick;
      compared++;
      if (bus.dry_fire !== 1'b0 || bus.busy !== 1'b0) begin
         mismatched++;
         $display("FAIL dry_fire_pulse: got dry=%b busy=%b required 0 0", bus.dry_fire, bus.busy);
      end
   endtask

   task automatic test_settle_light;
      int lat;
      logic hit;
      logic [31:0] pat = 32'h0001_FFFE;
      pulse_round_start;
      fire;
      exp_ammo--;
      do_sequence(1, pat, -1, -1, lat, hit);
      compared++;
      if (lat != LAT || hit !== window_hit(pat)) begin
         mismatched++;
         $display("FAIL settle_light: got lat=%0d hit=%b required lat=%0d hit=%b", lat, hit, LAT, window_hit(pat));
      end
      tick;
   endtask

   task automatic test_shot_during_sample;
      int lat;
      logic hit;
      logic [31:0] pat = $urandom;
      fire;
      exp_ammo--;
      do_sequence(2, pat, 20, -1, lat, hit);
`ifdef SHOT_BUFFER_EN
      exp_ammo--;
`endif
      compared++;
      if (lat != LAT || hit !== window_hit(pat) || bus.ammo !== 2'(exp_ammo)) begin
         mismatched++;
         $display("FAIL busy_shot: got lat=%0d hit=%b ammo=%0d required lat=%0d hit=%b ammo=%0d",
                  lat, hit, bus.ammo, LAT, window_hit(pat), exp_ammo);
      end
      tick;
`ifdef SHOT_BUFFER_EN
      compared++;
      if (bus.flash_req !== 1'b1) begin
         mismatched++;
         $display("FAIL busy_shot_chain: got req=%b required 1", bus.flash_req);
      end
      pat = $urandom;
      do_sequence(1, pat, -1, -1, lat, hit);
      compared++;
      if (lat != LAT || hit !== window_hit(pat)) begin
         mismatched++;
         $display("FAIL busy_shot_second: got lat=%0d hit=%b required lat=%0d hit=%b",
                  lat, hit, LAT, window_hit(pat));
      end
      tick;
`else
      compared++;
      if (bus.flash_req !== 1'b0 || bus.busy !== 1'b0) begin
         mismatched++;
         $display("FAIL busy_shot_drop: got req=%b busy=%b required 0 0", bus.flash_req, bus.busy);
      end
`endif
   endtask

   task automatic test_round_start;
      int lat;
      logic hit;
      pulse_round_start;
      fire;
      exp_ammo--;
      do_sequence(2, 32'hFFFF_FFFF, -1, 5, lat, hit);
      exp_ammo = AMMO_MAX;
      compared++;
      if (lat != LAT || hit !== 1'b1 || bus.ammo !== 2'(exp_ammo)) begin
         mismatched++;
         $display("FAIL round_start_settle: got lat=%0d hit=%b ammo=%0d required lat=%0d hit=1 ammo=%0d",
                  lat, hit, bus.ammo, LAT, exp_ammo);
      end
      tick;
      for (int i = 0; i < 2; i++) begin
         fire;
         exp_ammo--;
         do_sequence(0, 32'h0, -1, -1, lat, hit);
         tick;
      end
      compared++;
      if (bus.ammo !== 2'd1) begin
         mismatched++;
         $display("FAIL round_start_prep: got ammo=%0d required 1", bus.ammo);
      end
      bus.shot_state  = 2'b11;
      bus.round_start = 1'b1;
      tick;
      bus.shot_state  = 2'b00;
      bus.round_start = 1'b0;
      exp_ammo = AMMO_MAX;
      compared++;
      if (bus.ammo !== 2'(exp_ammo) || bus.flash_req !== 1'b0 || bus.busy !== 1'b0 || bus.dry_fire !== 1'b0) begin
         mismatched++;
         $display("FAIL round_start_coincident: got ammo=%0d req=%b busy=%b dry=%b required %0d 0 0 0",
                  bus.ammo, bus.flash_req, bus.busy, bus.dry_fire, exp_ammo);
      end
   endtask

   task automatic test_reset_mid;
      int valids = 0;
      fire;
      tick;
      bus.flash_ack = 1'b1;
      tick;
      bus.flash_ack   = 1'b0;
      bus.light_sense = 1'b1;
      repeat (19) tick;
      compared++;
      if (bus.busy !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_mid_busy: got busy=%b required 1", bus.busy);
      end
      reset_n = 1'b0;
      #1;
      compared++;
      if ({bus.flash_req, bus.result_valid, bus.result_hit, bus.busy, bus.dry_fire} !== 5'b0
          || bus.ammo !== 2'(AMMO_MAX)) begin
         mismatched++;
         $display("FAIL reset_mid: got outs=%b ammo=%0d required 00000 ammo=%0d",
                  {bus.flash_req, bus.result_valid, bus.result_hit, bus.busy, bus.dry_fire}, bus.ammo, AMMO_MAX);
      end
      tick;
      tick;
      reset_n = 1'b1;
      exp_ammo = AMMO_MAX;
      for (int i = 0; i < 40; i++) begin
         tick;
         if (bus.result_valid === 1'b1) valids++;
      end
      bus.light_sense = 1'b0;
      compared++;
      if (valids != 0) begin
         mismatched++;
         $display("FAIL reset_mid_no_result: got %0d result_valid pulses required 0", valids);
      end
   endtask

   task automatic test_random;
      int lat;
      logic hit;
      logic [31:0] pat;
      for (int it = 0; it < 8; it++) begin
         if (exp_ammo == 0) pulse_round_start;
         repeat ($urandom_range(0, 3)) begin
            bus.shot_state  = 2'($urandom_range(0, 2));
            bus.flash_ack   = 1'($urandom);
            bus.light_sense = 1'($urandom);
            tick;
         end
         bus.flash_ack   = 1'b0;
         bus.light_sense = 1'b0;
         compared++;
         if (bus.busy !== 1'b0 || bus.ammo !== 2'(exp_ammo)) begin
            mismatched++;
            $display("FAIL rand_idle%0d: got busy=%b ammo=%0d required 0 %0d", it, bus.busy, bus.ammo, exp_ammo);
         end
         fire;
         exp_ammo--;
         pat = $urandom;
         do_sequence($urandom_range(0, 4), pat, -1, -1, lat, hit);
         compared++;
         if (lat != LAT || hit !== window_hit(pat) || bus.ammo !== 2'(exp_ammo)) begin
            mismatched++;
            $display("FAIL rand_seq%0d: got lat=%0d hit=%b ammo=%0d required lat=%0d hit=%b ammo=%0d",
                     it, lat, hit, bus.ammo, LAT, window_hit(pat), exp_ammo);
         end
         tick;
      end
   endtask

   initial begin
      bus.shot_state  = 2'b00;
      bus.round_start = 1'b0;
      bus.flash_ack   = 1'b0;
      bus.light_sense = 1'b0;
      reset_n = 1'b0;
      repeat (3) tick;
      reset_n = 1'b1;
      test_reset;
      test_full_round;
      test_dry_fire;
      test_settle_light;
      test_shot_during_sample;
      test_round_start;
      test_reset_mid;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule

`default_nettype wire
